// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, the colour/timing types and the RGB332 expander
// used by the frame-buffer scan-out path.
package vga_pkg;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int H_FP_DEF       = 16;
  localparam int H_SYNC_DEF     = 96;
  localparam int H_BP_DEF       = 48;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int V_FP_DEF       = 10;
  localparam int V_SYNC_DEF     = 2;
  localparam int V_BP_DEF       = 33;
  localparam int CLK_DIV_DEF    = 2;
  localparam int RD_LATENCY_DEF = 1;

  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  localparam int COORD_W = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  // Sync/blank/frame-start bundle that travels alongside a pixel read.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
    logic fs;
  } timing_t;

  localparam timing_t TIMING_IDLE = '{hsync: 1'b1, vsync: 1'b1, blank: 1'b1, fs: 1'b0};

  // Bit replication keeps full-scale codes at 8'hFF and zero at 8'h00.
  function automatic rgb24_t rgb332_expand(input logic [7:0] c);
    rgb24_t p;
    p.r = {c[7:5], c[7:5], c[7:6]};
    p.g = {c[4:2], c[4:2], c[4:3]};
    p.b = {4{c[1:0]}};
    return p;
  endfunction

endpackage

// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port: the scan-out block issues coordinates and the
// picture array answers with an RGB332 word a fixed number of ticks later.
interface vga_frame_reader_if;
  import vga_pkg::*;

  logic               o_rd_en;
  logic [COORD_W-1:0] o_rd_x;
  logic [COORD_W-1:0] o_rd_y;
  logic [7:0]         i_color;

  modport master (output o_rd_en, output o_rd_x, output o_rd_y, input i_color);
  modport slave  (input o_rd_en, input o_rd_x, input o_rd_y, output i_color);

endinterface

// File: rtl/vga_timing_counter.sv
// Pixel-tick divider and raster counters; decodes raw sync/blank/frame-start
// for the counter position being issued on the current tick.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CLK_DIV  = CLK_DIV_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  output logic               tick,
  output logic               active,
  output logic [COORD_W-1:0] h_cnt,
  output logic [COORD_W-1:0] v_cnt,
  output timing_t            raw
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div;

  assign tick = (div == DIV_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      div   <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      div <= tick ? '0 : div + DIV_W'(1);
      if (tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + COORD_W'(1);
        end else begin
          h_cnt <= h_cnt + COORD_W'(1);
        end
      end
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default before any other
    // assignment so no path through the block can infer a latch.
    raw    = TIMING_IDLE;
    active = 1'b0;

    active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    raw.hsync = ~((h_cnt >= HS_START) && (h_cnt <= HS_END));
    raw.vsync = ~((v_cnt >= VS_START) && (v_cnt <= VS_END));
    raw.blank = ~active;
    raw.fs    = (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: rtl/vga_frame_reader.sv
// Frame-buffer scan-out: issues raster-order reads, delays sync/blank through
// the read latency and registers expanded RGB so colour and sync leave aligned.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  vga_frame_reader_if.master        fb,
  output logic [7:0]                o_red,
  output logic [7:0]                o_green,
  output logic [7:0]                o_blue,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      o_blank,
  output logic                      o_frame_start
);

  logic               tick;
  logic               active;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  timing_t            raw;

  // pipe[0] is the stage-0 copy taken with the read; pipe[RD_LATENCY] lines
  // up with the tick on which the returned word is valid.
  timing_t [RD_LATENCY:0] pipe;
  timing_t                tail;
  rgb24_t                 pix;

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_timing (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .tick   (tick),
    .active (active),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .raw    (raw)
  );

  assign tail = pipe[RD_LATENCY];

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      fb.o_rd_en    <= 1'b0;
      fb.o_rd_x     <= '0;
      fb.o_rd_y     <= '0;
      // NOTE: the whole delay line is cleared, not just its head, so a
      // restart can never emit sync or blank left over from an aborted frame.
      pipe          <= {(RD_LATENCY + 1){TIMING_IDLE}};
      pix           <= '0;
      hsync         <= 1'b1;
      vsync         <= 1'b1;
      o_blank       <= 1'b1;
      o_frame_start <= 1'b0;
    end else begin
      fb.o_rd_en    <= tick && active;
      o_frame_start <= 1'b0;
      if (tick) begin
        if (active) begin
          fb.o_rd_x <= h_cnt;
          fb.o_rd_y <= v_cnt;
        end
        pipe          <= {pipe[RD_LATENCY-1:0], raw};
        hsync         <= tail.hsync;
        vsync         <= tail.vsync;
        o_blank       <= tail.blank;
        o_frame_start <= tail.fs;
        pix           <= tail.blank ? '0 : rgb332_expand(fb.i_color);
      end
    end
  end

  assign o_red   = pix.r;
  assign o_green = pix.g;
  assign o_blue  = pix.b;

endmodule
